// File: rtl/tlc_pkg.sv
// Shared constants and types for the TLC5941-style LED driver receiver model.
package tlc_pkg;

   localparam int TLC_CHANNELS = 16;
   localparam int TLC_GS_BITS  = 12;
   localparam int TLC_DC_BITS  = 6;
   localparam int TLC_GS_LEN   = 192;
   localparam int TLC_DC_LEN   = 96;
   localparam int TLC_PWM_MAX  = 4095;

   localparam logic TLC_MODE_GS = 1'b0;
   localparam logic TLC_MODE_DC = 1'b1;

   typedef logic [11:0] gs_word_t;
   typedef logic [5:0]  dc_word_t;

endpackage

// File: rtl/tlc_receiver_edge_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse and a level output
// delayed to line up with that pulse (both appear 3 cycles after the pin edge).
module tlc_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic sync1_r;
   logic sync2_r;
   logic level_r;
   logic rise_r;

   // synchronizer chain and edge detect
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         level_r <= sync2_r;
         rise_r  <= sync2_r & ~level_r;
      end
   end

   assign level = level_r;
   assign rise  = rise_r;

endmodule

// File: rtl/tlc_receiver.sv
// TLC5941-style LED driver receiver: serial shift/latch, 12-bit PWM, 16 channels.
// Optional dot-correction register path enabled by macro TLC_DC_EN.
module tlc_receiver
   import tlc_pkg::*;
#(
   parameter int CHANNELS = TLC_CHANNELS,
   parameter int GS_BITS  = TLC_GS_BITS,
   parameter int DC_BITS  = TLC_DC_BITS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        led_sclk,
   input  logic                        led_sin,
   input  logic                        led_mode,
   input  logic                        led_blank,
   input  logic                        led_xlat,
   input  logic                        led_gsclk,
   output logic                        led_sout,
   output logic                        led_xerr_n,
   output logic [CHANNELS-1:0]         ch_out,
   output logic [CHANNELS*DC_BITS-1:0] dc_data,
   output logic                        frame_latched
);

   localparam int GS_LEN = CHANNELS * GS_BITS;
   localparam int DC_LEN = CHANNELS * DC_BITS;
   localparam logic [7:0] GS_LEN_CNT  = 8'(GS_LEN);
   localparam logic [7:0] BIT_CNT_MAX = 8'd255;
   localparam logic [GS_BITS-1:0] PWM_MAX = {GS_BITS{1'b1}};

   logic sclk_rise_s, sclk_lvl_s;
   logic xlat_rise_s, xlat_lvl_s;
   logic gsclk_rise_s, gsclk_lvl_s;
   logic blank_rise_s, blank_lvl_s;
   logic sin_rise_s, sin_lvl_s;
   logic mode_rise_s, mode_lvl_s;
   logic mode_chg_s;
   logic dc_msb_s;
   logic unused_s;

   logic                mode_q_r;
   logic [7:0]          bit_cnt_r;
   logic [GS_LEN-1:0]   gs_shift_r;
   logic [GS_LEN-1:0]   gs_latch_r;
   logic [GS_BITS-1:0]  pwm_cnt_r;
   logic                led_sout_r;
   logic                xerr_n_r;
   logic                frame_latched_r;
   logic [CHANNELS-1:0] ch_out_s;

   tlc_edge_sync u_sclk_sync  (.clock(clock), .reset(reset), .din(led_sclk),  .level(sclk_lvl_s),  .rise(sclk_rise_s));
   tlc_edge_sync u_xlat_sync  (.clock(clock), .reset(reset), .din(led_xlat),  .level(xlat_lvl_s),  .rise(xlat_rise_s));
   tlc_edge_sync u_gsclk_sync (.clock(clock), .reset(reset), .din(led_gsclk), .level(gsclk_lvl_s), .rise(gsclk_rise_s));
   tlc_edge_sync u_blank_sync (.clock(clock), .reset(reset), .din(led_blank), .level(blank_lvl_s), .rise(blank_rise_s));
   tlc_edge_sync u_sin_sync   (.clock(clock), .reset(reset), .din(led_sin),   .level(sin_lvl_s),   .rise(sin_rise_s));
   tlc_edge_sync u_mode_sync  (.clock(clock), .reset(reset), .din(led_mode),  .level(mode_lvl_s),  .rise(mode_rise_s));

   assign unused_s   = &{1'b0, sclk_lvl_s, xlat_lvl_s, gsclk_lvl_s, blank_rise_s, sin_rise_s, mode_rise_s};
   assign mode_chg_s = mode_lvl_s ^ mode_q_r;

   // bit counter: cleared by latch or mode change, otherwise counts shifts
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q_r  <= TLC_MODE_GS;
         bit_cnt_r <= 8'd0;
      end else begin
         mode_q_r <= mode_lvl_s;
         if (xlat_rise_s || mode_chg_s) begin
            bit_cnt_r <= 8'd0;
         end else if (sclk_rise_s && (bit_cnt_r != BIT_CNT_MAX)) begin
            bit_cnt_r <= bit_cnt_r + 8'd1;
         end else begin
            bit_cnt_r <= bit_cnt_r;
         end
      end
   end

   // grayscale shift and latch; a coincident shift is dropped so the latch sees pre-shift data
   always_ff @(posedge clock) begin
      if (reset) begin
         gs_shift_r <= {GS_LEN{1'b0}};
         gs_latch_r <= {GS_LEN{1'b0}};
      end else begin
         if (xlat_rise_s && (mode_lvl_s == TLC_MODE_GS)) begin
            gs_latch_r <= gs_shift_r;
         end
         if (sclk_rise_s && !xlat_rise_s && (mode_lvl_s == TLC_MODE_GS)) begin
            gs_shift_r <= {gs_shift_r[GS_LEN-2:0], sin_lvl_s};
         end
      end
   end

`ifdef TLC_DC_EN
   logic [DC_LEN-1:0] dc_shift_r;
   logic [DC_LEN-1:0] dc_latch_r;

   // dot-correction shift and latch
   always_ff @(posedge clock) begin
      if (reset) begin
         dc_shift_r <= {DC_LEN{1'b0}};
         dc_latch_r <= {DC_LEN{1'b1}};
      end else begin
         if (xlat_rise_s && (mode_lvl_s == TLC_MODE_DC)) begin
            dc_latch_r <= dc_shift_r;
         end
         if (sclk_rise_s && !xlat_rise_s && (mode_lvl_s == TLC_MODE_DC)) begin
            dc_shift_r <= {dc_shift_r[DC_LEN-2:0], sin_lvl_s};
         end
      end
   end

   assign dc_msb_s = dc_shift_r[DC_LEN-1];
   assign dc_data  = dc_latch_r;
`else
   assign dc_msb_s = 1'b0;
   assign dc_data  = {DC_LEN{1'b1}};
`endif

   // cascade output, framing flag and latch pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         led_sout_r      <= 1'b0;
         xerr_n_r        <= 1'b1;
         frame_latched_r <= 1'b0;
      end else begin
         led_sout_r <= (mode_lvl_s == TLC_MODE_DC) ? dc_msb_s : gs_shift_r[GS_LEN-1];
         if (xlat_rise_s && (mode_lvl_s == TLC_MODE_GS)) begin
            frame_latched_r <= 1'b1;
            xerr_n_r        <= (bit_cnt_r == GS_LEN_CNT);
         end else begin
            frame_latched_r <= 1'b0;
            xerr_n_r        <= xerr_n_r;
         end
      end
   end

   // PWM counter: blank wins over gsclk, saturates instead of wrapping
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_cnt_r <= {GS_BITS{1'b0}};
      end else if (blank_lvl_s) begin
         pwm_cnt_r <= {GS_BITS{1'b0}};
      end else if (gsclk_rise_s && (pwm_cnt_r != PWM_MAX)) begin
         pwm_cnt_r <= pwm_cnt_r + {{(GS_BITS-1){1'b0}}, 1'b1};
      end else begin
         pwm_cnt_r <= pwm_cnt_r;
      end
   end

   // channel compare against the live latch so updates apply mid-cycle
   always_comb begin
      ch_out_s = {CHANNELS{1'b0}};
      for (int n = 0; n < CHANNELS; n++) begin
         ch_out_s[n] = !blank_lvl_s && (pwm_cnt_r < gs_latch_r[n*GS_BITS +: GS_BITS]);
      end
   end

   assign ch_out        = ch_out_s;
   assign led_sout      = led_sout_r;
   assign led_xerr_n    = xerr_n_r;
   assign frame_latched = frame_latched_r;

endmodule

// File: tb/tb_tlc_receiver.sv
// Directed self-checking bench for tlc_receiver (DC expectations follow TLC_DC_EN).
module tb_tlc_receiver;

   logic        clock = 1'b0;
   logic        reset;
   logic        led_sclk, led_sin, led_mode, led_blank, led_xlat, led_gsclk;
   logic        led_sout, led_xerr_n, frame_latched;
   logic [15:0] ch_out;
   logic [95:0] dc_data;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   logic [191:0] frame1, frame2, frame3, exp_latch;
   logic [95:0]  dc_vec, dc_exp;
   logic [7:0]   pat;
   int           pulses, on0, on1, on15;

   tlc_receiver dut (
      .clock(clock), .reset(reset),
      .led_sclk(led_sclk), .led_sin(led_sin), .led_mode(led_mode),
      .led_blank(led_blank), .led_xlat(led_xlat), .led_gsclk(led_gsclk),
      .led_sout(led_sout), .led_xerr_n(led_xerr_n), .ch_out(ch_out),
      .dc_data(dc_data), .frame_latched(frame_latched)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [191:0] actual, input logic [191:0] expected);
      assert_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      led_sin  = b;
      led_sclk = 1'b1;
      tick(1);
      led_sclk = 1'b0;
      tick(1);
   endtask

   task automatic send_frame(input logic [191:0] f, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) send_bit(f[i]);
   endtask

   task automatic pulse_xlat(output int cnt);
      cnt = 0;
      led_xlat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (i == 0) led_xlat = 1'b0;
         if (frame_latched) cnt++;
      end
   endtask

   task automatic pulse_gsclk();
      led_gsclk = 1'b1;
      tick(1);
      led_gsclk = 1'b0;
      tick(4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   initial begin
      led_sclk = 1'b0; led_sin = 1'b0; led_mode = 1'b0;
      led_blank = 1'b1; led_xlat = 1'b0; led_gsclk = 1'b0;
      reset = 1'b1;
      for (int n = 0; n < 16; n++) begin
         frame1[n*12 +: 12] = (n == 15) ? 12'hFFF : ((n == 0) ? 12'h001 : 12'h800);
         frame2[n*12 +: 12] = 12'(n * 273);
         frame3[n*12 +: 12] = 12'(n * 16 + 5);
         dc_vec[n*6 +: 6]   = 6'h15;
      end
      tick(3);
      reset = 1'b0;
      tick(1);

      check("rst_xerr_n", led_xerr_n, 1'b1);
      check("rst_sout", led_sout, 1'b0);
      check("rst_ch_out", ch_out, 16'h0000);
      check("rst_frame_latched", frame_latched, 1'b0);
      check("rst_dc_data", dc_data, {96{1'b1}});
      check("rst_gs_latch", dut.gs_latch_r, 192'h0);
      tick(4);

      // full grayscale frame
      send_frame(frame1, 192);
      pulse_xlat(pulses);
      check("gs_frame_pulse", pulses, 1);
      check("gs_frame_xerr_n", led_xerr_n, 1'b1);
      check("gs_frame_latch", dut.gs_latch_r, frame1);

      // full PWM cycle
      led_blank = 1'b0;
      tick(4);
      on0 = 0; on1 = 0; on15 = 0;
      for (int c = 0; c < 4096; c++) begin
         if (ch_out[0])  on0++;
         if (ch_out[1])  on1++;
         if (ch_out[15]) on15++;
         if (c < 4095) pulse_gsclk();
      end
      check("pwm_ch0_counts", on0, 1);
      check("pwm_ch1_counts", on1, 2048);
      check("pwm_ch15_counts", on15, 4095);
      pulse_gsclk();
      check("pwm_saturate", dut.pwm_cnt_r, 12'd4095);
      check("pwm_end_ch_out", ch_out, 16'h0000);

      // blank mid-PWM
      led_blank = 1'b1; tick(4);
      led_blank = 1'b0; tick(4);
      for (int c = 0; c < 1000; c++) pulse_gsclk();
      check("blank_pre_cnt", dut.pwm_cnt_r, 12'd1000);
      check("blank_pre_ch_out", ch_out, 16'hFFFE);
      led_blank = 1'b1;
      tick(3);
      check("blank_ch_out_off", ch_out, 16'h0000);
      tick(1);
      check("blank_pwm_clear", dut.pwm_cnt_r, 12'd0);
      led_blank = 1'b0;
      tick(4);
      check("unblank_cnt", dut.pwm_cnt_r, 12'd0);
      check("unblank_ch_out", ch_out, 16'hFFFF);
      pulse_gsclk();
      check("unblank_cnt1", dut.pwm_cnt_r, 12'd1);
      check("unblank_ch_out1", ch_out, 16'hFFFE);

      // short frame
      send_frame(192'h0, 191);
      pulse_xlat(pulses);
      check("short_xerr_n", led_xerr_n, 1'b0);
      check("short_pulse", pulses, 1);
      exp_latch = frame1 << 191;
      check("short_latch", dut.gs_latch_r, exp_latch);

      // dot-correction frame
      led_mode = 1'b1;
      tick(4);
      send_frame({96'h0, dc_vec}, 96);
      pulse_xlat(pulses);
`ifdef TLC_DC_EN
      dc_exp = dc_vec;
`else
      dc_exp = {96{1'b1}};
`endif
      check("dc_data", dc_data, dc_exp);
      check("dc_no_pulse", pulses, 0);
      check("dc_xerr_kept", led_xerr_n, 1'b0);
      check("dc_gs_kept", dut.gs_latch_r, exp_latch);
      led_mode = 1'b0;
      tick(4);

      // good frame clears the error
      send_frame(frame2, 192);
      pulse_xlat(pulses);
      check("good_xerr_n", led_xerr_n, 1'b1);
      check("good_latch", dut.gs_latch_r, frame2);

      // cascade output
      do_reset();
      tick(4);
      pat = 8'hA5;
      for (int k = 0; k < 200; k++) begin
         send_bit(pat[7 - (k % 8)]);
         if (k >= 191) begin
            tick(4);
            check("cascade_sout", led_sout, pat[7 - ((k - 191) % 8)]);
         end
      end

      // reset mid-shift
      send_frame({192{1'b1}}, 100);
      do_reset();
      tick(4);
      check("midrst_bit_cnt", dut.bit_cnt_r, 8'd0);
      check("midrst_latch", dut.gs_latch_r, 192'h0);
      send_frame(frame3, 192);
      pulse_xlat(pulses);
      check("midrst_frame_latch", dut.gs_latch_r, frame3);
      check("midrst_xerr_n", led_xerr_n, 1'b1);
      check("midrst_pulse", pulses, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/tlc_receiver.md
Name: tlc_receiver

Overview:
- Cycle-accurate synthesizable model of one TLC5941-style constant-current LED driver: the receiving end of the serial LED bus that pixeldriver transmits on.
- Shifts in grayscale/dot-correction data on led_sclk and latches it on led_xlat.
- Runs the 12-bit PWM counter on led_gsclk and drives 16 channel outputs.
- Used in simulation benches and as an on-chip loopback target for checking the driver's framing; all inputs are sampled in the clock domain.

Parameters:
- CHANNELS, 16, number of output channels.
- GS_BITS, 12, grayscale bits per channel (shift length CHANNELS*GS_BITS = 192).
- DC_BITS, 6, dot-correction bits per channel (shift length CHANNELS*DC_BITS = 96).

Ports:
- clock  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- led_sclk  input  1  serial shift clock; data is sampled on its rising edge.
- led_sin  input  1  serial data, MSB (channel CHANNELS-1, bit msb) first.
- led_mode  input  1  0 = grayscale register, 1 = dot-correction register.
- led_blank  input  1  high = outputs off and PWM counter cleared.
- led_xlat  input  1  rising edge latches the shift register.
- led_gsclk  input  1  PWM count clock.
- led_sout  output  1  MSB of the active shift register (cascade output).
- led_xerr_n  output  1  active-low framing error flag.
- ch_out  output  CHANNELS  PWM channel outputs, 1 = LED on.
- dc_data  output  CHANNELS*DC_BITS  latched dot-correction values.
- frame_latched  output  1  one-cycle pulse on every grayscale latch.

Behaviour:
- Inputs are generated in the clock domain. Each high and low phase of an input lasts at least 1 clock.
- Every input goes through 2 registers plus a rising-edge detect, so the internal event fires 3 cycles after the pin edge. led_sin is delayed identically so it stays aligned with led_sclk.
- Reset values:
  - gs_shift, dc_shift, gs_latch and bit_cnt = 0.
  - pwm_cnt = 0.
  - dc_latch = all ones (63 per channel).
  - led_sout = 0, led_xerr_n = 1, ch_out = 0, frame_latched = 0.
  - Reset mid-shift discards partial data.
- Shift on an sclk event, mode 0: gs_shift <= {gs_shift[190:0], sin}. bit_cnt increments and saturates at 255.
- Shift on an sclk event, mode 1: dc_shift is shifted the same way, bit_cnt increments.
- led_sout is the registered MSB of gs_shift (mode 0) or dc_shift (mode 1).
- Latch on an xlat event, mode 0:
  - gs_latch <= gs_shift.
  - frame_latched pulses for 1 cycle.
  - If bit_cnt != 192, led_xerr_n <= 0. If bit_cnt == 192, led_xerr_n <= 1.
  - bit_cnt <= 0.
- Latch on an xlat event, mode 1: dc_latch <= dc_shift (when the feature is enabled), bit_cnt <= 0. led_xerr_n is unchanged.
- sclk and xlat events in the same cycle: the latch captures the pre-shift value and the shifted bit is dropped. bit_cnt ends at 0.
- led_mode change: bit_cnt <= 0. Shift register contents are kept.
- PWM, blank high: pwm_cnt <= 0 and ch_out = 0 combinationally from the synchronized blank.
- PWM, blank low: each gsclk event increments pwm_cnt, saturating at 4095 (no wrap).
- Channel output: ch_out[n] = !blank_s && (pwm_cnt < gs_latch[n]). GS = 0 never lights; GS = 4095 is on for 4095 counts.
- Blank event and gsclk event in the same cycle: blank wins.
- gs_latch updates take effect immediately, including mid-PWM-cycle.

Optional Feature:
- Macro TLC_DC_EN.
- Defined: dc_shift and dc_latch exist, and mode 1 behaves as described above.
- Undefined:
  - Mode 1 sclk events only increment bit_cnt; led_sout = 0 in mode 1.
  - Mode 1 xlat is ignored apart from bit_cnt <= 0.
  - dc_data is tied to all ones.
  - No DC registers are synthesized.

Decomposition:
- Package tlc_pkg holds:
  - TLC_GS_LEN = 192, TLC_DC_LEN = 96, TLC_PWM_MAX = 4095.
  - typedef gs_word_t [11:0] and dc_word_t [5:0].
  - Mode encodings TLC_MODE_GS = 0 and TLC_MODE_DC = 1.
- Sub-module tlc_edge_sync: 2-flop synchronizer plus registered rising-edge pulse, with a delayed-level output. Instantiated for sclk, xlat, gsclk and blank; sin and mode use its level path.

Test Plan:
- Grayscale frame: shift 192 bits giving ch15 = 0xFFF, ch0 = 0x001, all others 0x800, then pulse xlat. Expect:
  - frame_latched 1 cycle; led_xerr_n = 1.
  - After blank low and 4095 gsclk pulses, ch_out[0] high for exactly 1 count and ch_out[15] high for 4095 counts.
- Short frame: 191 sclk then xlat. Expect led_xerr_n = 0. A following good 192-bit frame returns it to 1.
- Blank mid-PWM: at pwm_cnt = 1000, raise blank. Expect ch_out = 0 within 3 cycles and pwm_cnt = 0. After blank falls, counting restarts at 0.
- Cascade: shift 200 bits of pattern 0xA5 repeating. led_sout must reproduce the first 8 bits, delayed by 192 sclk.
- Mode 1 with TLC_DC_EN: shift 96 bits giving all channels 0x15 and latch. Expect dc_data = 0x15 per channel, gs_latch unchanged, led_xerr_n unchanged. Without the macro, dc_data stays all ones.
- Reset mid-shift after 100 bits, then a full frame. gs_latch must equal the new frame only.
